// File: rtl/digota_pkg.sv
// Shared types and constants for the differential DIGOTA driver.
package digota_pkg;

  typedef enum logic [1:0] {OFF, CM_IN, RUN, CM_OUT} state_t;

  // Drive pair encoded as {INpb, INmb}, both active-low
  localparam logic [1:0] DRV_IDLE = 2'b11;
  localparam logic [1:0] DRV_CM   = 2'b00;
  localparam logic [1:0] DRV_POS  = 2'b01;
  localparam logic [1:0] DRV_NEG  = 2'b10;

  function automatic logic [31:0] midscale(input int w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/digota_dsm_mod.sv
// First-order delta-sigma modulator: the carry out of acc + code is the bitstream bit.
module digota_dsm_mod #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_code,
  output logic             o_bit
);

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, i_code};
  assign o_bit = w_sum[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) r_acc <= '0;
    else if (i_step)     r_acc <= w_sum[WIDTH-1:0];
  end

endmodule

// File: rtl/diff_digota_driver.sv
// Sequenced differential drive (OFF -> CM_IN -> RUN -> CM_OUT) for a digital OTA stage.
// Optional build macro DIGOTA_DEADTIME_EN inserts one IDLE cycle at each RUN polarity change.
module diff_digota_driver
  import digota_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CM_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] code,
  input  logic             code_valid,
  output logic             code_ready,
  output logic             INpb,
  output logic             INmb,
  output logic             oe,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CM_LAST = CNT_W'(CM_CYCLES - 1);

  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_code;
  logic [1:0]       r_drv, w_drv;
  logic             r_oe, r_busy, r_ready;
  logic             w_bit, w_step, w_clr, w_last, w_dead;

  assign w_last = (r_cnt == CM_LAST);

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = '0;
    case (r_state)
      OFF:    if (en) w_nxt = CM_IN;
      CM_IN: begin
        if (!en)         w_nxt = CM_OUT;
        else if (w_last) w_nxt = RUN;
        else             w_cnt_nxt = r_cnt + 1'b1;
      end
      RUN:    if (!en) w_nxt = CM_OUT;
      CM_OUT: begin
        // en is deliberately ignored here so the drain always completes
        if (w_last) w_nxt = OFF;
        else        w_cnt_nxt = r_cnt + 1'b1;
      end
      default: w_nxt = OFF;
    endcase
  end

  // The accumulator steps on every edge that lands in RUN and is held at zero
  // outside RUN, so each RUN entry starts from acc = 0.
  assign w_step = (w_nxt == RUN);
  assign w_clr  = !w_step && (r_state != RUN);

  digota_dsm_mod #(.WIDTH(WIDTH)) u_dsm (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_clr),
    .i_step (w_step),
    .i_code (r_code),
    .o_bit  (w_bit)
  );

`ifdef DIGOTA_DEADTIME_EN
  logic r_prev_bit;

  always_ff @(posedge clk) begin
    if (!rst_n)      r_prev_bit <= 1'b0;
    else if (w_step) r_prev_bit <= w_bit;
  end

  // No deadtime on the first RUN cycle: the previous drive was CM, not a polarity
  assign w_dead = (r_state == RUN) && (w_bit != r_prev_bit);
`else
  assign w_dead = 1'b0;
`endif

  always_comb begin
    w_drv = DRV_IDLE;
    case (w_nxt)
      CM_IN, CM_OUT: w_drv = DRV_CM;
      RUN:           w_drv = w_dead ? DRV_IDLE : (w_bit ? DRV_POS : DRV_NEG);
      default:       w_drv = DRV_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with r_state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= OFF;
      r_cnt   <= '0;
      r_code  <= WIDTH'(midscale(WIDTH));
      r_drv   <= DRV_IDLE;
      r_oe    <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
      if (code_valid && r_ready) r_code <= code;
      r_drv   <= w_drv;
      r_oe    <= (w_nxt != OFF);
      r_busy  <= (w_nxt != OFF);
      r_ready <= 1'b1;
    end
  end

  assign {INpb, INmb} = r_drv;
  assign oe           = r_oe;
  assign busy         = r_busy;
  assign code_ready   = r_ready;

endmodule

// File: tb/tb_diff_digota_driver.sv
// Scoreboard bench for diff_digota_driver: stimulus queues expected outputs, a negedge monitor checks them.
module tb_diff_digota_driver;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n, en, code_valid;
  logic [WIDTH-1:0] code;
  logic             code_ready, INpb, INmb, oe, busy;

  always #5 clk = ~clk;

  diff_digota_driver #(.WIDTH(WIDTH), .CM_CYCLES(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .INpb       (INpb),
    .INmb       (INmb),
    .oe         (oe),
    .busy       (busy)
  );

  typedef struct {
    logic [4:0] v;     // {oe, INpb, INmb, busy, code_ready}
    bit         ws;    // window start
    bit         we;    // window end
    int         wexp;  // expected POS cycles in window
    string      name;
  } exp_t;

  exp_t  q[$];
  int    checks = 0, errors = 0;
  int    pos_total = 0, pos_base = 0, ncyc = 0;
  bit    done = 1'b0;
  string phase = "init";

  // Reference modulator state
  int m_acc, m_code;
  bit m_prev, m_first;

  function automatic logic [1:0] model_step();
    int s;
    bit c, dt;
    s       = m_acc + m_code;
    c       = (s >= (1 << WIDTH));
    m_acc   = s % (1 << WIDTH);
    dt      = 1'b0;
`ifdef DIGOTA_DEADTIME_EN
    dt      = !m_first && (c != m_prev);
`endif
    m_prev  = c;
    m_first = 1'b0;
    return dt ? 2'b11 : (c ? 2'b01 : 2'b10);
  endfunction

  task automatic push(input logic o, input logic [1:0] drv, input logic r,
                      input bit ws = 1'b0, input bit we = 1'b0, input int wexp = 0);
    exp_t e;
    e.v    = {o, drv, o, r};
    e.ws   = ws;
    e.we   = we;
    e.wexp = wexp;
    e.name = phase;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_off();
    push(1'b0, 2'b11, 1'b1);
    tick();
  endtask

  task automatic cyc_cm(input int n);
    repeat (n) begin
      push(1'b1, 2'b00, 1'b1);
      tick();
    end
  endtask

  task automatic cyc_rst(input int n);
    repeat (n) begin
      push(1'b0, 2'b11, 1'b0);
      tick();
    end
  endtask

  task automatic run_entry();
    m_acc   = 0;
    m_first = 1'b1;
  endtask

  // wexp < 0: no window check over these cycles
  task automatic cyc_run(input int n, input int wexp = -1);
    int pc;
    logic [1:0] d;
    pc = 0;
    for (int i = 0; i < n; i++) begin
      d = model_step();
      if (d == 2'b01) pc++;
`ifdef DIGOTA_DEADTIME_EN
      push(1'b1, d, 1'b1, (wexp >= 0) && (i == 0), (wexp >= 0) && (i == n - 1), pc);
`else
      push(1'b1, d, 1'b1, (wexp >= 0) && (i == 0), (wexp >= 0) && (i == n - 1), wexp);
`endif
      tick();
    end
  endtask

  // The accepting cycle still steps with the old code
  task automatic handshake(input int newcode);
    code       = WIDTH'(newcode);
    code_valid = 1'b1;
    push(1'b1, model_step(), 1'b1);
    tick();
    code_valid = 1'b0;
    m_code     = newcode;
  endtask

  // Monitor / checker
  initial begin
    exp_t e;
    int   is_pos;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        ncyc++;
        is_pos = ({INpb, INmb} == 2'b01) ? 1 : 0;
        if (e.ws) pos_base = pos_total;
        pos_total += is_pos;
        checks++;
        if ({oe, INpb, INmb, busy, code_ready} !== e.v) begin
          errors++;
          $display("FAIL %s cyc %0d: oe/pb/mb/busy/rdy got %b expected %b",
                   e.name, ncyc, {oe, INpb, INmb, busy, code_ready}, e.v);
        end
`ifndef DIGOTA_DEADTIME_EN
        checks++;
        if (oe && {INpb, INmb} == 2'b11) begin
          errors++;
          $display("FAIL %s cyc %0d: forbidden oe=1 with IDLE drive", e.name, ncyc);
        end
`endif
        if (e.we) begin
          checks++;
          if (pos_total - pos_base != e.wexp) begin
            errors++;
            $display("FAIL %s density: POS count got %0d expected %0d",
                     e.name, pos_total - pos_base, e.wexp);
          end
        end
      end else if (done) begin
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; en = 1'b0; code_valid = 1'b0; code = '0;
    m_code = 128; m_acc = 0; m_prev = 1'b0; m_first = 1'b1;

    phase = "reset";    cyc_rst(2);
    rst_n = 1'b1;
    phase = "off";      cyc_off();

    phase = "startup";  en = 1'b1; cyc_cm(4); run_entry();
    phase = "run128";   cyc_run(256, 128);
    phase = "hs192";    handshake(192); cyc_run(256, 192);
    phase = "code0";    handshake(0);   cyc_run(256, 0);
    phase = "code255";  handshake(255); cyc_run(256, 255);
    phase = "code64";   handshake(64);  cyc_run(256, 64);

    // en drops in RUN and returns one cycle later: full drain, one OFF, full fill
    phase = "shutdown"; en = 1'b0; cyc_cm(1); en = 1'b1; cyc_cm(3);
    cyc_off();
    phase = "restart";  cyc_cm(4); run_entry();
    phase = "rerun64";  cyc_run(8);

    // en dropped part-way through CM_IN
    phase = "drain";    en = 1'b0; cyc_cm(4); cyc_off();
    phase = "abort";    en = 1'b1; cyc_cm(2); en = 1'b0; cyc_cm(4); cyc_off(); cyc_off();

    // Reset from RUN; code_reg must come back at midscale
    phase = "pre_rst";  en = 1'b1; cyc_cm(4); run_entry(); cyc_run(20);
    phase = "mid_rst";  rst_n = 1'b0; cyc_rst(2); rst_n = 1'b1; m_code = 128;
    phase = "post_rst"; cyc_cm(4); run_entry();
    phase = "run_mid";  cyc_run(256, 128);
    phase = "final";    en = 1'b0; cyc_cm(4); cyc_off();

    done = 1'b1;
  end

endmodule
